// File: rtl/sqrt_u32.sv
// sqrt_u32 -- pipelined unsigned integer square root, z = floor(sqrt(a)).
//
// Restoring digit recurrence that produces one root bit per stage and takes
// two radicand bits per stage, MSB first. The pipeline accepts one operand
// every clock and has no handshake.
//   Latency: WIDTH/2 cycles, or WIDTH/2+1 cycles with SQRT_ROUND_EN.
//
// Ports:
//   clk  in   1      rising-edge clock
//   rst  in   1      synchronous active-high reset; clears every stage and z
//   a    in   WIDTH  unsigned radicand, sampled every cycle
//   z    out  WIDTH  unsigned root, registered
//
// Configuration macro:
//   SQRT_ROUND_EN  when defined, z = round-to-nearest sqrt(a). This adds one
//                  register stage. The result can then reach 2^(WIDTH/2).
//
// Parameters:
//   WIDTH  operand/result width; must be even and >= 4

module sqrt_u32 #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] z
);

   localparam int unsigned H  = WIDTH / 2;  // number of recurrence stages
   localparam int unsigned RW = H + 2;      // partial remainder width
   localparam int unsigned TW = RW + 2;     // trial (shifted remainder) width

   // Stage-input registers. Index 0 is the input register for a. At index 0
   // the remainder and root are always zero, so stage 0 starts from a clean
   // recurrence state.
   logic [WIDTH-1:0] rad_q  [H];
   logic [WIDTH-1:0] rad_d  [H];
   logic [RW-1:0]    rem_q  [H];
   logic [RW-1:0]    rem_d  [H];
   logic [H-1:0]     root_q [H];
   logic [H-1:0]     root_d [H];

   // Per-stage combinational recurrence step.
   logic [TW-1:0]    cur_w   [H];
   logic [TW-1:0]    sub_w   [H];
   logic             fit_w   [H];
   logic [RW-1:0]    remn_w  [H];
   logic [H-1:0]     rootn_w [H];

   logic [WIDTH-1:0] z_q;
   logic [WIDTH-1:0] z_d;

`ifdef SQRT_ROUND_EN
   logic [RW-1:0]    remf_q;
   logic [H-1:0]     rootf_q;
`endif

   always_comb begin
      for (int unsigned k = 0; k < H; k++) begin
         cur_w[k]   = {rem_q[k], rad_q[k][WIDTH-1 -: 2]};
         sub_w[k]   = {2'b00, root_q[k], 2'b01};
         fit_w[k]   = (cur_w[k] >= sub_w[k]);
         // The kept remainder never exceeds 2*root, so it always fits RW bits.
         remn_w[k]  = fit_w[k] ? RW'(cur_w[k] - sub_w[k]) : cur_w[k][RW-1:0];
         rootn_w[k] = {root_q[k][H-2:0], fit_w[k]};
      end
   end

   always_comb begin
      rad_d[0]  = a;
      rem_d[0]  = '0;
      root_d[0] = '0;
      for (int unsigned k = 1; k < H; k++) begin
         rad_d[k]  = rad_q[k-1] << 2;
         rem_d[k]  = remn_w[k-1];
         root_d[k] = rootn_w[k-1];
      end
   end

`ifdef SQRT_ROUND_EN
   // The remainder is a - r*r, so "rem > r" is the same test as a > r*r + r.
   always_comb begin
      if (remf_q > RW'(rootf_q)) begin
         z_d = WIDTH'({1'b0, rootf_q} + (H+1)'(1));
      end else begin
         z_d = WIDTH'(rootf_q);
      end
   end
`else
   always_comb begin
      z_d = WIDTH'(rootn_w[H-1]);
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned k = 0; k < H; k++) begin
            rad_q[k]  <= '0;
            rem_q[k]  <= '0;
            root_q[k] <= '0;
         end
`ifdef SQRT_ROUND_EN
         remf_q  <= '0;
         rootf_q <= '0;
`endif
         z_q <= '0;
      end else begin
         for (int unsigned k = 0; k < H; k++) begin
            rad_q[k]  <= rad_d[k];
            rem_q[k]  <= rem_d[k];
            root_q[k] <= root_d[k];
         end
`ifdef SQRT_ROUND_EN
         remf_q  <= remn_w[H-1];
         rootf_q <= rootn_w[H-1];
`endif
         z_q <= z_d;
      end
   end

   assign z = z_q;

endmodule

// File: tb/tb_sqrt_u32.sv
// tb_sqrt_u32 -- scoreboard bench for sqrt_u32 (WIDTH=32).
//
// The driver pushes one expected result for every rising edge. When it asserts
// reset, it also zeroes every entry still in flight. The monitor pops one entry
// for every edge once LAT+1 entries are queued, and compares that entry with z.
// Build with SQRT_ROUND_EN defined to check the rounding variant.

module tb_sqrt_u32;

`ifdef SQRT_ROUND_EN
   localparam int unsigned LAT = 17;
`else
   localparam int unsigned LAT = 16;
`endif

   typedef struct {
      logic [31:0] a;
      logic [31:0] exp;
   } entry_t;

   logic        clk;
   logic        rst;
   logic [31:0] a;
   logic [31:0] z;

   entry_t exp_q[$];
   int unsigned checks;
   int unsigned errors;
   int unsigned slot;

   sqrt_u32 #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .a   (a),
      .z   (z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model. It finds the floor root by binary search on r*r <= v.
   function automatic logic [31:0] ref_sqrt(input logic [31:0] v);
      longint unsigned lo, hi, mid, r;
      lo = 0;
      hi = 65535;
      while (lo < hi) begin
         mid = (lo + hi + 1) / 2;
         if (mid * mid <= longint'(v)) lo = mid;
         else hi = mid - 1;
      end
      r = lo;
`ifdef SQRT_ROUND_EN
      if (longint'(v) > r * r + r) r = r + 1;
`endif
      return 32'(r);
   endfunction

   // Drive one cycle of stimulus and record what the DUT must output for it.
   task automatic drive(input logic r, input logic [31:0] v, input logic [31:0] e);
      entry_t ent;
      @(negedge clk);
      rst = r;
      a   = v;
      if (r) begin
         for (int i = 0; i < exp_q.size(); i++) exp_q[i].exp = '0;
      end
      ent.a   = v;
      ent.exp = r ? 32'd0 : e;
      exp_q.push_back(ent);
   endtask

   // Monitor
   initial begin
      entry_t ent;
      slot = 0;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > LAT) begin
            ent = exp_q.pop_front();
            checks++;
            if (z !== ent.exp) begin
               errors++;
               $display("FAIL z slot %0d (a=%0d): got %0d expected %0d",
                        slot, ent.a, z, ent.exp);
            end
            slot++;
         end
      end
   end

   // Directed corners: radicand, floor result, rounded result
   localparam int NDIR = 17;
   logic [31:0] dir_a     [NDIR] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4,
                                     32'd15, 32'd16, 32'd17, 32'd24, 32'd99,
                                     32'd100, 32'd999999, 32'd1000000,
                                     32'd4294836225, 32'hFFFFFFFF,
                                     32'h40000000, 32'd2};
   logic [31:0] dir_floor [NDIR] = '{32'd0, 32'd1, 32'd1, 32'd1, 32'd2,
                                     32'd3, 32'd4, 32'd4, 32'd4, 32'd9,
                                     32'd10, 32'd999, 32'd1000,
                                     32'd65535, 32'd65535,
                                     32'd32768, 32'd1};
   logic [31:0] dir_round [NDIR] = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd2,
                                     32'd4, 32'd4, 32'd4, 32'd5, 32'd10,
                                     32'd10, 32'd1000, 32'd1000,
                                     32'd65535, 32'd65536,
                                     32'd32768, 32'd1};

   initial begin
      entry_t ent;
      logic [31:0] v;
      checks = 0;
      errors = 0;

      // Reset is held for three edges with a nonzero a; the first entry covers
      // the edge at t=5.
      rst = 1'b1;
      a   = 32'd12345;
      ent.a   = 32'd12345;
      ent.exp = '0;
      exp_q.push_back(ent);
      drive(1'b1, 32'd12345, 32'd0);
      drive(1'b1, 32'd12345, 32'd0);

      // Directed corners, one per cycle
      for (int i = 0; i < NDIR; i++) begin
`ifdef SQRT_ROUND_EN
         drive(1'b0, dir_a[i], dir_round[i]);
`else
         drive(1'b0, dir_a[i], dir_floor[i]);
`endif
      end

      // Back-to-back random stream with a one-cycle reset pulse in the middle
      for (int i = 0; i < 450; i++) begin
         v = $urandom;
         if (i == 200) drive(1'b1, v, 32'd0);
         else          drive(1'b0, v, ref_sqrt(v));
      end

      // Flush the pipeline with zeros
      for (int i = 0; i < int'(LAT) + 3; i++) drive(1'b0, 32'd0, 32'd0);
      @(negedge clk);

      // Every slot except the last LAT must already have been compared
      checks++;
      if (exp_q.size() != LAT) begin
         errors++;
         $display("FAIL scoreboard depth: got %0d expected %0d", exp_q.size(), LAT);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
